// File: rtl/enc_pkg.sv
// Shared definitions for the encoder event queue: code width, the "no input
// active" code, the queued entry layout and the legal-code check.
package enc_pkg;

    localparam int ENC_W    = 8;
    localparam int DEF_TS_W = 8;
    localparam logic [ENC_W-1:0] NO_HIT = 8'hF0;

    typedef struct packed {
        logic [ENC_W-1:0]    code;
        logic [DEF_TS_W-1:0] ts;
    } enc_entry_t;

    // An encoder result is either an input index 0..15 or the no-hit marker.
    function automatic logic is_legal_code(input logic [ENC_W-1:0] code,
                                           input logic [ENC_W-1:0] no_hit);
        return (code[ENC_W-1:4] == '0) || (code == no_hit);
    endfunction

endpackage

// File: rtl/enc_event_queue_if.sv
// Readout stream of the event queue: head entry plus valid/ready handshake.
interface enc_event_queue_if
    import enc_pkg::*;
#(
    parameter int TS_W = 8
);
    logic             out_valid;
    logic             out_ready;
    logic [ENC_W-1:0] out_code;
    logic [TS_W-1:0]  out_ts;

    modport master (output out_valid, output out_code, output out_ts, input out_ready);
    modport slave  (input out_valid, input out_code, input out_ts, output out_ready);
endinterface

// File: rtl/enc_event_fifo.sv
// Generic synchronous FIFO with a registered head word; a pop request is
// ignored while empty and a push into a full FIFO is dropped unless a pop frees a slot.
module enc_event_fifo #(
    parameter int W     = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_push,
    input  logic [W-1:0]             i_din,
    input  logic                     i_pop,
    output logic                     o_valid,
    output logic [W-1:0]             o_dout,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_drop
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [W-1:0]     r_mem [DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [W-1:0]     r_head;

    logic             w_pop;
    logic             w_full;
    logic             w_push_ok;
    logic [PTR_W-1:0] w_rd_next;
    logic [CNT_W-1:0] w_remain;

    assign w_pop     = i_pop && (r_count != '0);
    assign w_full    = (r_count == CNT_W'(DEPTH));
    assign w_push_ok = i_push && (!w_full || w_pop);
    assign w_rd_next = r_rd_ptr + PTR_W'(w_pop);
    // Entries already stored that survive this edge's pop.
    assign w_remain  = r_count - CNT_W'(w_pop);

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_din;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_head   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            r_rd_ptr <= w_rd_next;
            r_count  <= r_count + CNT_W'(w_push_ok) - CNT_W'(w_pop);
            // The new head is an older stored entry if one remains, otherwise
            // the word being pushed now bypasses the array.
            if (w_remain != '0) begin
                r_head <= r_mem[w_rd_next];
            end else if (w_push_ok) begin
                r_head <= i_din;
            end
        end
    end

    assign o_valid = (r_count != '0);
    assign o_dout  = r_head;
    assign o_count = r_count;
    assign o_drop  = i_push && w_full && !w_pop;

endmodule

// File: rtl/enc_event_queue.sv
// Watches the priority encoder code, timestamps every change of the highest
// active input and queues it for a valid/ready readout.
module enc_event_queue
    import enc_pkg::ENC_W;
    import enc_pkg::is_legal_code;
#(
    parameter int               DEPTH  = 8,
    parameter int               TS_W   = 8,
    parameter logic [ENC_W-1:0] NO_HIT = enc_pkg::NO_HIT
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   ena,
    input  logic [ENC_W-1:0]       enc_code,
    input  logic                   clr_flags,
    enc_event_queue_if.master      out_if,
    output logic [$clog2(DEPTH):0] count,
    output logic                   overflow,
    output logic                   err
);
    logic [TS_W-1:0]       r_ts;
    logic [ENC_W-1:0]      r_last_code;
    logic                  r_overflow;
    logic                  r_err;

    logic                  w_legal;
    logic                  w_push;
    logic                  w_err_set;
    logic                  w_drop;
    logic [ENC_W+TS_W-1:0] w_head;

    assign w_legal   = is_legal_code(enc_code, NO_HIT);
    assign w_push    = ena && w_legal && (enc_code != r_last_code);
    assign w_err_set = ena && !w_legal;

    // Illegal codes never update last_code, so the next legal code is
    // compared against the last legal one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ts        <= '0;
            r_last_code <= NO_HIT;
            r_overflow  <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            if (ena) begin
                r_ts <= r_ts + 1'b1;
                if (w_legal) begin
                    r_last_code <= enc_code;
                end
            end
            r_overflow <= w_drop    | (r_overflow & ~clr_flags);
            r_err      <= w_err_set | (r_err & ~clr_flags);
        end
    end

    enc_event_fifo #(
        .W     (ENC_W + TS_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_push  (w_push),
        .i_din   ({enc_code, r_ts}),
        .i_pop   (out_if.out_ready),
        .o_valid (out_if.out_valid),
        .o_dout  (w_head),
        .o_count (count),
        .o_drop  (w_drop)
    );

    assign out_if.out_code = w_head[TS_W +: ENC_W];
    assign out_if.out_ts   = w_head[TS_W-1:0];
    assign overflow        = r_overflow;
    assign err             = r_err;

endmodule

// File: tb/tb_enc_event_queue.sv
// Randomised and directed bench for enc_event_queue against a queue-based
// model of the change-detect / timestamp / FIFO rules.
module tb_enc_event_queue;
    localparam int         DEPTH  = 8;
    localparam int         TS_W   = 8;
    localparam logic [7:0] NO_HIT = 8'hF0;

    typedef struct packed {
        logic [7:0]      code;
        logic [TS_W-1:0] ts;
    } ent_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ena = 1'b0;
    logic [7:0] enc_code = NO_HIT;
    logic       clr_flags = 1'b0;
    logic [3:0] count;
    logic       overflow;
    logic       err;

    enc_event_queue_if #(.TS_W(TS_W)) out_if ();

    enc_event_queue #(.DEPTH(DEPTH), .TS_W(TS_W), .NO_HIT(NO_HIT)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena       (ena),
        .enc_code  (enc_code),
        .clr_flags (clr_flags),
        .out_if    (out_if),
        .count     (count),
        .overflow  (overflow),
        .err       (err)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    ent_t            m_q[$];
    logic [TS_W-1:0] m_ts;
    logic [7:0]      m_last;
    bit              m_ovf;
    bit              m_err;

    function automatic bit legal(input logic [7:0] c);
        return (c <= 8'd15) || (c == NO_HIT);
    endfunction

    task automatic model_reset();
        m_q.delete();
        m_ts   = '0;
        m_last = NO_HIT;
        m_ovf  = 0;
        m_err  = 0;
    endtask

    // Advance one clock edge and apply the queue rules to the model.
    task automatic tick();
        bit   pop, push, drop, eset;
        ent_t e;
        @(posedge clk);
        pop  = (m_q.size() > 0) && out_if.out_ready;
        push = ena && legal(enc_code) && (enc_code != m_last);
        eset = ena && !legal(enc_code);
        drop = 0;
        e.code = enc_code;
        e.ts   = m_ts;
        if (pop) m_q.delete(0);
        if (push) begin
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else drop = 1;
        end
        m_ovf = drop ? 1'b1 : (clr_flags ? 1'b0 : m_ovf);
        m_err = eset ? 1'b1 : (clr_flags ? 1'b0 : m_err);
        if (ena) begin
            if (legal(enc_code)) m_last = enc_code;
            m_ts = m_ts + 1'b1;
        end
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        out_if.out_ready = 1'b0;
        clr_flags = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        ena = 1'b1;
        enc_code = NO_HIT;
        out_if.out_ready = 1'b0;
        #12;
        vectors++;
        if ({out_if.out_valid, count, overflow, err, out_if.out_code, out_if.out_ts} !== '0) begin
            miscompares++;
            $display("FAIL reset_outputs: got valid=%b count=%0d ovf=%b err=%b code=%h ts=%h required all 0",
                     out_if.out_valid, count, overflow, err, out_if.out_code, out_if.out_ts);
        end
        do_reset();
        repeat (20) tick();
        vectors++;
        if ({out_if.out_valid, count, overflow, err} !== 7'd0) begin
            miscompares++;
            $display("FAIL idle_nohit: got valid=%b count=%0d ovf=%b err=%b required 0 0 0 0",
                     out_if.out_valid, count, overflow, err);
        end
    endtask

    task automatic test_first_event();
        do_reset();
        ena = 1'b1;
        enc_code = NO_HIT;
        repeat (5) tick();
        enc_code = 8'd3;
        vectors++;
        if (out_if.out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL first_pre_valid: got %b required 0", out_if.out_valid);
        end
        tick();
        vectors++;
        if ({out_if.out_valid, count, out_if.out_code, out_if.out_ts} !== {1'b1, 4'd1, 8'd3, 8'd5}) begin
            miscompares++;
            $display("FAIL first_entry: got valid=%b count=%0d code=%0d ts=%0d required 1 1 3 5",
                     out_if.out_valid, count, out_if.out_code, out_if.out_ts);
        end
        repeat (10) tick();
        vectors++;
        if (count !== 4'd1) begin
            miscompares++;
            $display("FAIL steady_code: got count=%0d required 1", count);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] exp_code;
        out_if.out_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            enc_code = (i % 2 == 0) ? 8'd7 : 8'd3;
            tick();
        end
        vectors++;
        if ({count, overflow, out_if.out_code, out_if.out_ts} !== {4'd8, 1'b1, 8'd3, 8'd5}) begin
            miscompares++;
            $display("FAIL overflow_state: got count=%0d ovf=%b head=%0d/%0d required 8 1 3/5",
                     count, overflow, out_if.out_code, out_if.out_ts);
        end
        out_if.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            exp_code = (i % 2 == 0) ? 8'd3 : 8'd7;
            vectors++;
            if ({out_if.out_valid, out_if.out_code} !== {1'b1, exp_code}) begin
                miscompares++;
                $display("FAIL drain_order[%0d]: got valid=%b code=%0d required 1 %0d",
                         i, out_if.out_valid, out_if.out_code, exp_code);
            end
            tick();
        end
        out_if.out_ready = 1'b0;
        vectors++;
        if ({out_if.out_valid, count} !== 5'd0) begin
            miscompares++;
            $display("FAIL drain_empty: got valid=%b count=%0d required 0 0", out_if.out_valid, count);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] last_out;
        int         n;
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        for (int i = 0; i < 8; i++) begin
            enc_code = (i % 2 == 0) ? 8'd7 : 8'd3;
            tick();
        end
        out_if.out_ready = 1'b1;
        enc_code = 8'd15;
        tick();
        vectors++;
        if ({count, overflow} !== {4'd8, 1'b0}) begin
            miscompares++;
            $display("FAIL full_push_pop: got count=%0d ovf=%b required 8 0", count, overflow);
        end
        last_out = 8'h00;
        n = 0;
        while (out_if.out_valid === 1'b1 && n < 20) begin
            last_out = out_if.out_code;
            tick();
            n++;
        end
        vectors++;
        if ({n[7:0], last_out} !== {8'd8, 8'd15}) begin
            miscompares++;
            $display("FAIL full_tail: got pops=%0d last=%0d required 8 15", n, last_out);
        end
        out_if.out_ready = 1'b0;
    endtask

    task automatic test_err_clr();
        logic [TS_W-1:0] exp_ts;
        enc_code = 8'd3;
        tick();
        enc_code = 8'h20;
        tick();
        vectors++;
        if ({err, count} !== {1'b1, 4'd1}) begin
            miscompares++;
            $display("FAIL err_set: got err=%b count=%0d required 1 1", err, count);
        end
        enc_code = 8'd3;
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        vectors++;
        if ({err, count} !== {1'b0, 4'd1}) begin
            miscompares++;
            $display("FAIL err_clear: got err=%b count=%0d required 0 1", err, count);
        end
        enc_code = NO_HIT;
        exp_ts = m_ts;
        tick();
        out_if.out_ready = 1'b1;
        tick();
        out_if.out_ready = 1'b0;
        vectors++;
        if ({out_if.out_valid, out_if.out_code, out_if.out_ts} !== {1'b1, NO_HIT, exp_ts}) begin
            miscompares++;
            $display("FAIL nohit_event: got valid=%b code=%h ts=%0d required 1 f0 %0d",
                     out_if.out_valid, out_if.out_code, out_if.out_ts, exp_ts);
        end
        out_if.out_ready = 1'b1;
        tick();
        out_if.out_ready = 1'b0;
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            enc_code = 8'(i + 4);
            tick();
        end
        vectors++;
        if (count !== 4'd5) begin
            miscompares++;
            $display("FAIL prefill: got count=%0d required 5", count);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        vectors++;
        if ({out_if.out_valid, count} !== 5'd0) begin
            miscompares++;
            $display("FAIL async_reset: got valid=%b count=%0d required 0 0", out_if.out_valid, count);
        end
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        ena = 1'b1;
        enc_code = 8'd0;
        tick();
        vectors++;
        if ({out_if.out_valid, out_if.out_code, out_if.out_ts} !== {1'b1, 8'd0, 8'd0}) begin
            miscompares++;
            $display("FAIL post_reset_event: got valid=%b code=%0d ts=%0d required 1 0 0",
                     out_if.out_valid, out_if.out_code, out_if.out_ts);
        end
    endtask

    task automatic test_random();
        int   r;
        ent_t h;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            ena = ($urandom_range(0, 99) < 85);
            out_if.out_ready = ($urandom_range(0, 99) < 40);
            clr_flags = ($urandom_range(0, 99) < 5);
            if ($urandom_range(0, 1) == 1) begin
                r = $urandom_range(0, 19);
                if (r < 12)      enc_code = 8'($urandom_range(0, 3));
                else if (r < 16) enc_code = NO_HIT;
                else if (r < 18) enc_code = 8'($urandom_range(0, 15));
                else             enc_code = 8'h10 + 8'($urandom_range(0, 127));
            end
            tick();
            h = (m_q.size() > 0) ? m_q[0] : '0;
            vectors++;
            if (out_if.out_valid !== (m_q.size() > 0) || count !== 4'(m_q.size()) ||
                overflow !== m_ovf || err !== m_err ||
                (m_q.size() > 0 && {out_if.out_code, out_if.out_ts} !== h)) begin
                miscompares++;
                $display("FAIL random[%0d]: got v=%b cnt=%0d ovf=%b err=%b head=%h/%0d required v=%b cnt=%0d ovf=%b err=%b head=%h/%0d",
                         cyc, out_if.out_valid, count, overflow, err, out_if.out_code, out_if.out_ts,
                         (m_q.size() > 0), m_q.size(), m_ovf, m_err, h.code, h.ts);
            end
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        out_if.out_ready = 1'b0;
        model_reset();
        test_reset();
        test_first_event();
        test_overflow();
        test_full_push_pop();
        test_err_clr();
        test_async_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/enc_event_queue.md
Name: enc_event_queue

Overview:
- Downstream consumer of the 16-input priority encoder's 8-bit result code.
- Watches the code every clock and detects changes in the highest active input.
- Stamps each change with a free-running cycle timestamp and buffers it in a small FIFO.
- A readout stage (host logic or a later serializer) drains the FIFO through a valid/ready handshake.

Parameters:
- DEPTH, 8, FIFO entries; power of two, 2..32.
- TS_W, 8, timestamp counter width in bits.
- NO_HIT, 8'hF0, encoder code meaning "no input active".

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- ena  input  1  enable; when low, sampling and timestamp are frozen but pops still work.
- enc_code  input  8  encoder result: 0..15 or NO_HIT.
- clr_flags  input  1  synchronous clear of the overflow and err sticky flags.
- out_ready  input  1  consumer accepts the head entry.
- out_valid  output  1  FIFO is non-empty; head entry is valid.
- out_code  output  8  head entry code.
- out_ts  output  TS_W  head entry timestamp.
- count  output  clog2(DEPTH)+1  number of occupied entries.
- overflow  output  1  sticky: an event was dropped because the FIFO was full.
- err  output  1  sticky: an illegal code was presented.

Behaviour:
- Reset (async assert, sync-released by system): all outputs are 0.
  - Internal last_code = NO_HIT, ts = 0, read/write pointers = 0.
  - All pending entries are discarded, including when reset hits mid-operation.
- Timestamp:
  - ts increments by 1 on every edge with ena=1 and wraps from 2^TS_W-1 to 0.
  - ts holds when ena=0.
- Legal codes: 0..15 and NO_HIT. Any other value:
  - sets err and pushes nothing;
  - leaves last_code unchanged;
  - holds err until clr_flags or reset.
- Change detect, evaluated on a rising edge with ena=1 and a legal enc_code:
  - if enc_code != last_code, a push is requested with entry {enc_code, ts (pre-increment value)};
  - last_code <= enc_code, whether or not the push succeeds.
- Push latency: an entry pushed at edge N is visible on out_* and counted in count after edge N (registered outputs only).
  - For the first entry into an empty FIFO, out_valid rises in the cycle after edge N.
- Pop: happens at an edge where out_valid=1 and out_ready=1. The next entry, or out_valid=0, appears after that edge.
  - out_ready while out_valid=0 is ignored.
  - out_code and out_ts are stable while out_valid=1 and out_ready=0.
- Full:
  - a push with count==DEPTH and no pop at the same edge is dropped and sets overflow;
  - the existing entries are unchanged.
- Simultaneous push and pop:
  - when full: the pop frees a slot, the push is accepted, count stays DEPTH, overflow does not set;
  - when non-empty and not full: count is unchanged, FIFO order is preserved.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- clr_flags and a new overflow/err at the same edge: the set wins.
- Steady code: repeated equal codes push nothing. A NO_HIT following an index is a legal event and is queued.

Decomposition:
- Shared package enc_pkg:
  - NO_HIT constant, ENC_W=8;
  - an entry struct/typedef {code[7:0], ts[TS_W-1:0]};
  - an is_legal_code function.
- Sub-module enc_event_fifo: a generic synchronous FIFO with a push/pop/full/empty/count interface and registered head output.
- Top level: change detector, timestamp counter, sticky flags.

Test Plan:
- Reset, then enc_code held at NO_HIT for 20 cycles -> out_valid=0, count=0, overflow=0, err=0.
- After reset, ena=1, enc_code=NO_HIT until cycle 5, then 8'd3 -> one entry {8'd3, ts=5}, out_valid=1 one cycle later. enc_code held at 3 for 10 cycles -> count stays 1.
- out_ready=0, enc_code toggling 3,7,3,7... for 10 distinct changes with DEPTH=8 -> count=8, overflow=1, head still {3,5}. Then pop 8 with out_ready=1 -> codes 3,7,3,7,3,7,3,7 in order, count reaches 0.
- FIFO full, out_ready=1, new change (code 15) at the same edge -> count stays 8, overflow unchanged, last entry out is 15.
- enc_code=8'h20 -> err=1, count unchanged. clr_flags pulse -> err=0. Next change 3→NO_HIT queues {8'hF0, ts}.
- rst_n asserted asynchronously with 5 entries queued -> out_valid and count drop to 0 before the next edge. After release, the first change to 0 is queued with ts=0.
